// File: rtl/game_fsm.sv
// Round sequencer for the two-player game: menu, countdown, gameplay and game-over
// phases, with per-player health, post-hit invulnerability and winner decision.
module game_fsm #(
  parameter int MAX_HEALTH      = 3,
  parameter int COUNTDOWN_START = 3,
  parameter int STEP_TICKS      = 60,
  parameter int INVULN_TICKS    = 20,
  parameter int GAME_OVER_TICKS = 300
) (
  input  logic       clk_game,
  input  logic       reset,
  input  logic       start_btn,
  input  logic       p1_hit,
  input  logic       p2_hit,
  output logic [2:0] current_game_state,
  output logic [2:0] p1_health,
  output logic [2:0] p2_health,
  output logic       game_over,
  output logic [1:0] countdown_digit,
  output logic [1:0] winner
);

  typedef enum logic [2:0] {
    MENU      = 3'b000,
    COUNTDOWN = 3'b001,
    GAMEPLAY  = 3'b010,
    GAME_OVER = 3'b011
  } state_t;

  localparam int SW = $clog2(STEP_TICKS + 1);
  localparam int IW = $clog2(INVULN_TICKS + 1);
  localparam int HW = $clog2(GAME_OVER_TICKS + 1);

  state_t          state;
  logic [SW-1:0]   step_cnt;
  logic [IW-1:0]   inv1;
  logic [IW-1:0]   inv2;
  logic [HW-1:0]   hold_cnt;
  logic            start_prev;
  logic            start_edge;
  logic            p1_take;
  logic            p2_take;
  logic [2:0]      p1_next;
  logic [2:0]      p2_next;

  assign current_game_state = state;
  assign start_edge         = start_btn & ~start_prev;

  // A hit only lands on a vulnerable player with health left, so health never wraps.
  always_comb begin
    p1_take = p1_hit && (inv1 == '0) && (p1_health != 3'd0);
    p2_take = p2_hit && (inv2 == '0) && (p2_health != 3'd0);
    p1_next = p1_take ? p1_health - 3'd1 : p1_health;
    p2_next = p2_take ? p2_health - 3'd1 : p2_health;
  end

  // NOTE: every register here uses <= so all updates see the pre-edge values together.
  always_ff @(posedge clk_game or posedge reset) begin
    if (reset) begin
      state           <= MENU;
      step_cnt        <= '0;
      inv1            <= '0;
      inv2            <= '0;
      hold_cnt        <= '0;
      start_prev      <= 1'b1;
      p1_health       <= 3'(MAX_HEALTH);
      p2_health       <= 3'(MAX_HEALTH);
      game_over       <= 1'b0;
      countdown_digit <= 2'd0;
      winner          <= 2'b00;
    end else begin
      start_prev <= start_btn;
      case (state)
        MENU: begin
          p1_health <= 3'(MAX_HEALTH);
          p2_health <= 3'(MAX_HEALTH);
          winner    <= 2'b00;
          if (start_edge) begin
            state           <= COUNTDOWN;
            countdown_digit <= 2'(COUNTDOWN_START);
            step_cnt        <= '0;
          end
        end

        COUNTDOWN: begin
          if (step_cnt == SW'(STEP_TICKS - 1)) begin
            step_cnt <= '0;
            if (countdown_digit == 2'd1) begin
              state           <= GAMEPLAY;
              countdown_digit <= 2'd0;
            end else begin
              countdown_digit <= countdown_digit - 2'd1;
            end
          end else begin
            step_cnt <= step_cnt + 1'b1;
          end
        end

        GAMEPLAY: begin
          p1_health <= p1_next;
          p2_health <= p2_next;
          if (p1_take)            inv1 <= IW'(INVULN_TICKS);
          else if (inv1 != '0)    inv1 <= inv1 - 1'b1;
          if (p2_take)            inv2 <= IW'(INVULN_TICKS);
          else if (inv2 != '0)    inv2 <= inv2 - 1'b1;
          if ((p1_next == 3'd0) || (p2_next == 3'd0)) begin
            state     <= GAME_OVER;
            game_over <= 1'b1;
            hold_cnt  <= '0;
            winner    <= {p1_next == 3'd0, p2_next == 3'd0};
          end
        end

        GAME_OVER: begin
          if (start_edge || (hold_cnt == HW'(GAME_OVER_TICKS - 1))) begin
            state     <= MENU;
            p1_health <= 3'(MAX_HEALTH);
            p2_health <= 3'(MAX_HEALTH);
            winner    <= 2'b00;
            inv1      <= '0;
            inv2      <= '0;
            hold_cnt  <= '0;
            game_over <= 1'b0;
          end else begin
            hold_cnt <= hold_cnt + 1'b1;
          end
        end

        default: begin
          state           <= MENU;
          p1_health       <= 3'(MAX_HEALTH);
          p2_health       <= 3'(MAX_HEALTH);
          winner          <= 2'b00;
          inv1            <= '0;
          inv2            <= '0;
          hold_cnt        <= '0;
          game_over       <= 1'b0;
          countdown_digit <= 2'd0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_game_fsm.sv
// Bench for game_fsm: directed rounds plus random hits/starts against a timeline
// model that tracks phase entry times and last-accepted-hit times.
module tb_game_fsm;

  localparam int MAXH = 3;
  localparam int CS   = 3;
  localparam int ST   = 4;
  localparam int INV  = 5;
  localparam int GO   = 8;

  logic       clk_game = 1'b0;
  logic       reset;
  logic       start_btn;
  logic       p1_hit;
  logic       p2_hit;
  logic [2:0] current_game_state;
  logic [2:0] p1_health;
  logic [2:0] p2_health;
  logic       game_over;
  logic [1:0] countdown_digit;
  logic [1:0] winner;

  game_fsm #(
    .MAX_HEALTH(MAXH), .COUNTDOWN_START(CS), .STEP_TICKS(ST),
    .INVULN_TICKS(INV), .GAME_OVER_TICKS(GO)
  ) dut (
    .clk_game(clk_game), .reset(reset), .start_btn(start_btn),
    .p1_hit(p1_hit), .p2_hit(p2_hit),
    .current_game_state(current_game_state),
    .p1_health(p1_health), .p2_health(p2_health),
    .game_over(game_over), .countdown_digit(countdown_digit), .winner(winner)
  );

  always #5 clk_game = ~clk_game;

  int errors = 0;
  int checks = 0;

  // Model: phase 0..3, time of phase entry, time of each player's last accepted hit.
  int cyc;
  int m_phase;
  int m_hp1;
  int m_hp2;
  int m_win;
  int t_enter;
  int last1;
  int last2;
  bit m_prev;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_phase = 0;
    m_hp1   = MAXH;
    m_hp2   = MAXH;
    m_win   = 0;
    t_enter = 0;
    last1   = -1000;
    last2   = -1000;
    m_prev  = 1'b1;
  endtask

  task automatic model_tick();
    bit st_edge;
    bit a1;
    bit a2;
    cyc++;
    st_edge = start_btn && !m_prev;
    m_prev  = start_btn;
    case (m_phase)
      0: if (st_edge) begin
        m_phase = 1;
        t_enter = cyc;
      end
      1: if (cyc - t_enter == CS * ST) begin
        m_phase = 2;
        t_enter = cyc;
        last1   = -1000;
        last2   = -1000;
      end
      2: begin
        a1 = p1_hit && (m_hp1 > 0) && (cyc - last1 > INV);
        a2 = p2_hit && (m_hp2 > 0) && (cyc - last2 > INV);
        if (a1) begin m_hp1--; last1 = cyc; end
        if (a2) begin m_hp2--; last2 = cyc; end
        if (m_hp1 == 0 || m_hp2 == 0) begin
          m_phase = 3;
          t_enter = cyc;
          m_win   = (m_hp1 == 0 ? 2 : 0) + (m_hp2 == 0 ? 1 : 0);
        end
      end
      default: if (st_edge || (cyc - t_enter == GO)) begin
        m_phase = 0;
        m_hp1   = MAXH;
        m_hp2   = MAXH;
        m_win   = 0;
      end
    endcase
  endtask

  task automatic check_all(input string tag);
    int dig;
    dig = (m_phase == 1) ? CS - (cyc - t_enter) / ST : 0;
    check({tag, ".state"},  current_game_state, 8'(m_phase));
    check({tag, ".hp1"},    p1_health,          8'(m_hp1));
    check({tag, ".hp2"},    p2_health,          8'(m_hp2));
    check({tag, ".over"},   game_over,          8'(m_phase == 3));
    check({tag, ".digit"},  countdown_digit,    8'(dig));
    check({tag, ".winner"}, winner,             8'(m_win));
  endtask

  task automatic step(input string tag);
    @(posedge clk_game);
    if (reset) model_reset();
    else       model_tick();
    #1 check_all(tag);
  endtask

  task automatic start_round(input string tag);
    start_btn = 1'b0;
    step({tag, "_lo"});
    start_btn = 1'b1;
    step({tag, "_hi"});
  endtask

  initial begin
    cyc       = 0;
    reset     = 1'b1;
    start_btn = 1'b1;
    p1_hit    = 1'b0;
    p2_hit    = 1'b0;
    model_reset();
    #2 check_all("reset");
    step("reset_hold");
    step("reset_hold");
    reset = 1'b0;

    // Button held through reset must not start a game.
    repeat (3) step("btn_held");
    check("btn_held_menu", current_game_state, 8'd0);

    start_round("start1");
    check("start1_state", current_game_state, 8'd1);
    check("start1_digit", countdown_digit, 8'd3);

    repeat (CS * ST) begin
      p1_hit = ($urandom_range(0, 1) == 1);
      p2_hit = ($urandom_range(0, 1) == 1);
      step("countdown");
    end
    p1_hit = 1'b0;
    p2_hit = 1'b0;
    check("play_state", current_game_state, 8'd2);
    check("play_digit", countdown_digit, 8'd0);

    // Continuous p1 hits: accepted every INV+1 cycles, then ignored in GAME_OVER.
    p1_hit = 1'b1;
    repeat (20) step("p1_stream");
    check("p1_dead", p1_health, 8'd0);
    check("p1_winner", winner, 8'd2);
    check("p1_over", game_over, 8'd1);
    p1_hit = 1'b0;
    step("go_auto");
    check("go_auto_state", current_game_state, 8'd0);
    check("go_auto_hp1", p1_health, 8'd3);
    check("go_auto_win", winner, 8'd0);

    // Simultaneous hits down to a draw.
    start_round("start2");
    repeat (CS * ST) step("countdown2");
    repeat (3) begin
      p1_hit = 1'b1;
      p2_hit = 1'b1;
      step("both_hit");
      p1_hit = 1'b0;
      p2_hit = 1'b0;
      if (current_game_state == 3'd2) repeat (INV) step("both_wait");
    end
    check("draw_state", current_game_state, 8'd3);
    check("draw_winner", winner, 8'd3);

    // Start edge in GAME_OVER returns to MENU ahead of the hold timer.
    p1_hit = 1'b1;
    start_round("go_start");
    p1_hit = 1'b0;
    check("go_start_state", current_game_state, 8'd0);

    // Random play.
    repeat (600) begin
      if ($urandom_range(0, 15) == 0) start_btn = ~start_btn;
      p1_hit = ($urandom_range(0, 3) == 0);
      p2_hit = ($urandom_range(0, 3) == 0);
      step("random");
    end
    p1_hit = 1'b0;
    p2_hit = 1'b0;

    // Asynchronous reset in the middle of a round.
    start_round("start3");
    repeat (CS * ST) step("countdown3");
    p1_hit = 1'b1;
    step("pre_reset");
    p1_hit = 1'b0;
    step("pre_reset");
    #2 reset = 1'b1;
    #1 model_reset();
    check_all("async_reset");
    step("in_reset");
    reset = 1'b0;
    step("post_reset");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
